// File: rtl/alu_issue_ctrl.sv
// Instruction-issue sequencer: fetches, decodes and sequences ALU operations and branches.
// Optional: define ALU_ISSUE_TRAP_EN to trap on illegal encodings (branch=1, single=1).
module alu_issue_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          REG_AW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    output logic              mem_req,
    output logic [15:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [15:0]       rf_rdata1,
    input  logic [15:0]       rf_rdata2,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [15:0]       rf_wdata,
    output logic [15:0]       alu_value1,
    output logic [15:0]       alu_value2,
    output logic [3:0]        alu_operator,
    output logic              alu_single,
    input  logic [15:0]       alu_result,
    input  logic              alu_check_branch,
    output logic [15:0]       pc,
    output logic              busy,
    output logic              trap
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB,
        S_BRANCH,
        S_TRAP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        pend_q, pend_d;
    logic [15:0] alu_value1_q, alu_value1_d;
    logic [15:0] alu_value2_q, alu_value2_d;
    logic [3:0]  alu_operator_q, alu_operator_d;
    logic        alu_single_q, alu_single_d;

    logic        ir_single;
    logic        ir_branch;
    logic        ir_nowb;
    logic [15:0] br_offset;

    assign ir_single = ir_q[11];
    assign ir_branch = ir_q[10];
    assign ir_nowb   = ir_q[9];
    assign br_offset = {{6{ir_q[9]}}, ir_q[9:0]};

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        pend_d         = 1'b0;
        alu_value1_d   = alu_value1_q;
        alu_value2_d   = alu_value2_q;
        alu_operator_d = alu_operator_q;
        alu_single_d   = alu_single_q;
        mem_req        = 1'b0;
        rf_we          = 1'b0;
        rf_waddr       = '0;
        rf_wdata       = '0;

        case (state_q)
            S_FETCH: begin
                // A request that was already presented at an edge is held through halt until acked.
                mem_req = rst_n && (!halt || pend_q);
                pend_d  = mem_req && !mem_ack;
                if (mem_req && mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_branch && !ir_single) begin
                    alu_operator_d = ir_q[15:12];
                    state_d        = S_BRANCH;
                end else if (!ir_branch) begin
                    state_d = S_READ;
                end else begin
`ifdef ALU_ISSUE_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_READ: begin
                alu_value1_d   = rf_rdata1;
                alu_value2_d   = rf_rdata2;
                alu_operator_d = ir_q[15:12];
                alu_single_d   = ir_single;
                state_d        = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                if (!ir_nowb) begin
                    rf_we    = rst_n;
                    rf_waddr = REG_AW'(ir_q[7:4]);
                    rf_wdata = alu_result;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                // pc already points past the branch word, so the offset is relative to the next word.
                if (alu_check_branch) begin
                    pc_d = pc_q + br_offset;
                end
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            ir_q           <= '0;
            pend_q         <= 1'b0;
            alu_value1_q   <= '0;
            alu_value2_q   <= '0;
            alu_operator_q <= '0;
            alu_single_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            pend_q         <= pend_d;
            alu_value1_q   <= alu_value1_d;
            alu_value2_q   <= alu_value2_d;
            alu_operator_q <= alu_operator_d;
            alu_single_q   <= alu_single_d;
        end
    end

    assign mem_addr     = pc_q;
    assign pc           = pc_q;
    assign rf_raddr1    = REG_AW'(ir_q[7:4]);
    assign rf_raddr2    = REG_AW'(ir_q[3:0]);
    assign alu_value1   = alu_value1_q;
    assign alu_value2   = alu_value2_q;
    assign alu_operator = alu_operator_q;
    assign alu_single   = alu_single_q;
    assign busy         = (state_q != S_FETCH);
`ifdef ALU_ISSUE_TRAP_EN
    assign trap         = (state_q == S_TRAP);
`else
    assign trap         = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: bench acts as instruction memory, register file and ALU,
// and compares the sequencer against an instruction-level reference model.
module tb_alu_issue_ctrl;

    localparam logic [15:0] RST_PC = 16'h0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] alu_value1, alu_value2;
    logic [3:0]  alu_operator;
    logic        alu_single;
    logic [15:0] alu_result;
    logic        alu_check_branch;
    logic [15:0] pc;
    logic        busy;
    logic        trap;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf_mem [16];
    logic [15:0] mdl_rf [16];
    logic [15:0] exp_pc;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.RESET_PC(RST_PC), .REG_AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_value1(alu_value1), .alu_value2(alu_value2), .alu_operator(alu_operator),
        .alu_single(alu_single), .alu_result(alu_result), .alu_check_branch(alu_check_branch),
        .pc(pc), .busy(busy), .trap(trap)
    );

    function automatic logic [15:0] alu_fn(logic [3:0] op, logic [15:0] a, logic [15:0] b, logic s);
        if (s) return ~a;
        case (op)
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // Environment: combinational register file reads and a registered ALU.
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];
    always @(posedge clk) alu_result <= alu_fn(alu_operator, alu_value1, alu_value2, alu_single);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction word and follow it until the next fetch request (or a bound expires).
    task automatic run_instr(input logic [15:0] word, input int dly, input bit take, input bit hold_halt);
        logic [3:0]  op, rd, rs2;
        logic        s, br, nowb;
        logic        is_alu, exp_trap;
        int          exp_lat, exp_we, lat, we_cnt;
        logic [15:0] exp_v1, exp_v2, exp_wdata;

        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk);
        chk("req_seen", mem_req, 1);
        for (int d = 0; d < dly; d++) begin
            if (hold_halt && d > 0) halt = 1'b1;
            #1;
            chk("wait_req", mem_req, 1);
            chk("wait_addr", mem_addr, exp_pc);
            chk("wait_pc", pc, exp_pc);
            @(negedge clk);
        end
        chk("fetch_addr", mem_addr, exp_pc);
        mem_ack          = 1'b1;
        mem_rdata        = word;
        alu_check_branch = take;

        op = word[15:12]; s = word[11]; br = word[10]; nowb = word[9];
        rd = word[7:4];   rs2 = word[3:0];
        exp_pc    = exp_pc + 16'd1;
        is_alu    = !br;
        exp_trap  = 1'b0;
        exp_we    = 0;
        exp_v1    = mdl_rf[rd];
        exp_v2    = mdl_rf[rs2];
        exp_wdata = alu_fn(op, exp_v1, exp_v2, s);
        if (!br) begin
            exp_lat = 5;
            exp_we  = nowb ? 0 : 1;
        end else if (!s) begin
            exp_lat = 3;
            if (take) exp_pc = exp_pc + {{6{word[9]}}, word[9:0]};
        end else begin
`ifdef ALU_ISSUE_TRAP_EN
            exp_lat  = -1;
            exp_trap = 1'b1;
`else
            exp_lat  = 2;
`endif
        end

        lat    = -1;
        we_cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                mem_ack = 1'b0;
                halt    = 1'b0;
            end
            if (rf_we === 1'b1) begin
                we_cnt++;
                chk("wb_addr", rf_waddr, rd);
                chk("wb_data", rf_wdata, exp_wdata);
                rf_mem[rf_waddr] = rf_wdata;
            end
            if (n == 3 && is_alu) begin
                chk("exec_v1", alu_value1, exp_v1);
                chk("exec_v2", alu_value2, exp_v2);
                chk("exec_op", alu_operator, op);
                chk("exec_single", alu_single, s);
            end
            if (n == 2 && exp_trap) begin
                chk("trap_flag", trap, 1);
                chk("trap_busy", busy, 1);
            end
            if (mem_req === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (is_alu && exp_we == 1) mdl_rf[rd] = exp_wdata;
        chk("latency", lat, exp_lat);
        chk("we_count", we_cnt, exp_we);
        chk("pc", pc, exp_pc);
        chk("trap", trap, exp_trap);
    endtask

    initial begin
        logic [15:0] w, v, off;
        rst_n = 1'b0; halt = 1'b0; mem_ack = 1'b0; mem_rdata = '0; alu_check_branch = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = 16'($urandom);
            rf_mem[i] = v;
            mdl_rf[i] = v;
        end
        rf_mem[2] = 16'd5; mdl_rf[2] = 16'd5;
        rf_mem[3] = 16'd7; mdl_rf[3] = 16'd7;

        // Reset for two cycles.
        @(negedge clk);
        chk("rst_req0", mem_req, 0);
        @(negedge clk);
        chk("rst_req1", mem_req, 0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_busy", busy, 0);
        chk("rst_trap", trap, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_v1", alu_value1, 0);
        chk("rst_op", alu_operator, 0);
        chk("rst_wdata", rf_wdata, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_req", mem_req, 1);
        chk("rel_addr", mem_addr, RST_PC);
        exp_pc = RST_PC;

        // ADD r2,r3 -> r2 = 12; then compare-style with no writeback.
        run_instr(16'h0023, 0, 1'b0, 1'b0);
        chk("add_r2", rf_mem[2], 16'd12);
        run_instr(16'h1245, 0, 1'b0, 1'b0);
        // Delayed ack, then delayed ack with halt raised while pending.
        run_instr(16'h4067, 4, 1'b0, 1'b0);
        run_instr(16'h3089, 3, 1'b0, 1'b1);

        // Halt while idle in FETCH: no request, pc frozen.
        halt = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("halt_req", mem_req, 0);
            chk("halt_busy", busy, 0);
            chk("halt_pc", pc, exp_pc);
            @(negedge clk);
        end
        halt = 1'b0;

        // Branch to pc=1, then the directed branch cases and the pc wrap.
        off = 16'h0001 - (exp_pc + 16'h0001);
        run_instr({6'b0111_01, off[9:0]}, 0, 1'b1, 1'b0);
        chk("at_pc1", pc, 16'h0001);
        run_instr(16'h77FE, 0, 1'b1, 1'b0);
        chk("br_taken", pc, 16'h0000);
        run_instr(16'h7400, 0, 1'b1, 1'b0);
        run_instr(16'h77FE, 0, 1'b0, 1'b0);
        chk("br_not_taken", pc, 16'h0002);
        run_instr(16'h77FC, 0, 1'b1, 1'b0);
        chk("at_ffff", pc, 16'hFFFF);
        run_instr(16'h0011, 1, 1'b0, 1'b0);
        chk("wrap", pc, 16'h0000);

        // Randomized legal instructions.
        for (int k = 0; k < 40; k++) begin
            w = 16'($urandom);
            if (w[10]) w[11] = 1'b0;
            run_instr(w, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset during writeback aborts the instruction with no write strobe.
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 16'h0023;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstwb_we", rf_we, 0);
        chk("rstwb_req", mem_req, 0);
        @(negedge clk);
        chk("rstwb_we2", rf_we, 0);
        chk("rstwb_pc", pc, RST_PC);
        chk("rstwb_busy", busy, 0);
        rst_n = 1'b1;
        exp_pc = RST_PC;
        chk("rstwb_r2", rf_mem[2], mdl_rf[2]);

        // Illegal encoding: trap or NOP depending on build.
        run_instr(16'h0C00, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
